// File: rtl/vram_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | vram_pkg : shared constants, register map and FSM encoding for vram_blitter |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package vram_pkg;

  localparam int c_aw_default = 13;
  localparam int c_lw_default = 13;

  localparam logic [2:0] c_reg_dst_l = 3'd0;
  localparam logic [2:0] c_reg_dst_h = 3'd1;
  localparam logic [2:0] c_reg_src_l = 3'd2;
  localparam logic [2:0] c_reg_src_h = 3'd3;
  localparam logic [2:0] c_reg_len_l = 3'd4;
  localparam logic [2:0] c_reg_len_h = 3'd5;
  localparam logic [2:0] c_reg_fill  = 3'd6;
  localparam logic [2:0] c_reg_ctrl  = 3'd7;

  localparam int c_ctrl_start  = 0;
  localparam int c_ctrl_mode   = 1;
  localparam int c_ctrl_irq_en = 2;
  localparam int c_ctrl_abort  = 3;
  localparam int c_ctrl_done   = 7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } blt_state_t;

endpackage
`default_nettype wire

// File: rtl/vram_blitter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | vram_blitter : byte fill/copy engine sharing the CPU side of the VRAM port  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module vram_blitter
  import vram_pkg::*;
#(
  parameter int AW = c_aw_default,
  parameter int LW = c_lw_default
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_sel_ram,
  input  logic          cpu_sel_blt,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_rdata,
  output logic          m_sel,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [7:0]    m_wdata,
  input  logic [7:0]    m_rdata,
  output logic          busy,
  output logic          irq
);

  blt_state_t r_state, w_next_state;

  logic [AW-1:0] r_dst, r_src, r_cur_dst, r_cur_src;
  logic [LW-1:0] r_len, r_cur_len;
  logic [7:0]    r_fill, r_hold, r_rdata;
  logic          r_mode, r_irq_en, r_done, r_rd_blt, r_rd_ram;

  logic          w_busy, w_reg_wr, w_ctrl_wr, w_abort, w_start, w_grant, w_len_zero;
  logic          w_load, w_step, w_capture;
  logic          w_blt_sel, w_blt_we;
  logic [AW-1:0] w_blt_addr;
  logic [7:0]    w_blt_wdata, w_reg_rdata;

  assign w_busy     = r_state inside {ST_RD, ST_CAP, ST_WR};
  assign w_reg_wr   = cpu_sel_blt & cpu_we;
  assign w_ctrl_wr  = w_reg_wr & (cpu_addr[2:0] == c_reg_ctrl);
  assign w_abort    = w_ctrl_wr & cpu_din[c_ctrl_abort] & w_busy;
  assign w_start    = w_ctrl_wr & cpu_din[c_ctrl_start] & ~w_busy;
  assign w_grant    = ~cpu_sel_ram;
  assign w_len_zero = (r_len == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Abort in the same cycle also withdraws the port request, so no byte slips out.
  always_comb begin
    w_next_state = r_state;
    w_blt_sel    = 1'b0;
    w_blt_we     = 1'b0;
    w_blt_addr   = '0;
    w_blt_wdata  = 8'h00;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        w_next_state = ST_IDLE;
        if (w_start && !w_len_zero) begin
          w_load       = 1'b1;
          w_next_state = cpu_din[c_ctrl_mode] ? ST_RD : ST_WR;
        end
      end
      ST_RD: begin
        w_blt_sel  = 1'b1;
        w_blt_addr = r_cur_src;
        if (w_grant) w_next_state = ST_CAP;
      end
      ST_CAP: begin
        w_capture    = 1'b1;
        w_next_state = ST_WR;
      end
      ST_WR: begin
        w_blt_sel   = 1'b1;
        w_blt_we    = 1'b1;
        w_blt_addr  = r_cur_dst;
        w_blt_wdata = r_mode ? r_hold : r_fill;
        if (w_grant) begin
          w_step = 1'b1;
          if (r_cur_len == LW'(1)) w_next_state = ST_DONE;
          else                     w_next_state = r_mode ? ST_RD : ST_WR;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
    if (w_abort) begin
      w_next_state = ST_IDLE;
      w_blt_sel    = 1'b0;
      w_blt_we     = 1'b0;
      w_step       = 1'b0;
      w_capture    = 1'b0;
    end
  end

  always_comb begin
    m_sel   = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = 8'h00;
    if (cpu_sel_ram) begin
      m_sel   = 1'b1;
      m_we    = cpu_we;
      m_addr  = cpu_addr;
      m_wdata = cpu_din;
    end else if (w_blt_sel) begin
      m_sel   = 1'b1;
      m_we    = w_blt_we;
      m_addr  = w_blt_addr;
      m_wdata = w_blt_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dst    <= '0;
      r_src    <= '0;
      r_len    <= '0;
      r_fill   <= 8'h00;
      r_mode   <= 1'b0;
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      if (w_reg_wr && !w_busy) begin
        case (cpu_addr[2:0])
          c_reg_dst_l: r_dst[7:0]    <= cpu_din;
          c_reg_dst_h: r_dst[AW-1:8] <= cpu_din[AW-9:0];
          c_reg_src_l: r_src[7:0]    <= cpu_din;
          c_reg_src_h: r_src[AW-1:8] <= cpu_din[AW-9:0];
          c_reg_len_l: r_len[7:0]    <= cpu_din;
          c_reg_len_h: r_len[LW-1:8] <= cpu_din[LW-9:0];
          c_reg_fill:  r_fill        <= cpu_din;
          c_reg_ctrl:  r_mode        <= cpu_din[c_ctrl_mode];
          default: ;
        endcase
      end
      if (w_ctrl_wr) r_irq_en <= cpu_din[c_ctrl_irq_en];
      // Completion outranks a simultaneous clear; clear-then-start lets a zero-length start set done.
      if (w_ctrl_wr && cpu_din[c_ctrl_done]) r_done <= 1'b0;
      if ((w_start && w_len_zero) || w_next_state == ST_DONE || r_state == ST_DONE)
        r_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cur_dst <= '0;
      r_cur_src <= '0;
      r_cur_len <= '0;
      r_hold    <= 8'h00;
    end else begin
      if (w_load) begin
        r_cur_dst <= r_dst;
        r_cur_src <= r_src;
        r_cur_len <= r_len;
      end else if (w_step) begin
        r_cur_dst <= r_cur_dst + AW'(1);
        r_cur_src <= r_cur_src + AW'(1);
        r_cur_len <= r_cur_len - LW'(1);
      end
      if (w_capture) r_hold <= m_rdata;
    end
  end

  always_comb begin
    w_reg_rdata = 8'h00;
    case (cpu_addr[2:0])
      c_reg_dst_l: w_reg_rdata = r_dst[7:0];
      c_reg_dst_h: w_reg_rdata = {{(16-AW){1'b0}}, r_dst[AW-1:8]};
      c_reg_src_l: w_reg_rdata = r_src[7:0];
      c_reg_src_h: w_reg_rdata = {{(16-AW){1'b0}}, r_src[AW-1:8]};
      c_reg_len_l: w_reg_rdata = r_len[7:0];
      c_reg_len_h: w_reg_rdata = {{(16-LW){1'b0}}, r_len[LW-1:8]};
      c_reg_fill:  w_reg_rdata = r_fill;
      c_reg_ctrl:  w_reg_rdata = {r_done, 4'b0000, r_irq_en, r_mode, w_busy};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata  <= 8'h00;
      r_rd_blt <= 1'b0;
      r_rd_ram <= 1'b0;
    end else begin
      if (cpu_sel_blt && !cpu_we) r_rdata <= w_reg_rdata;
      r_rd_blt <= cpu_sel_blt & ~cpu_we;
      r_rd_ram <= cpu_sel_ram & ~cpu_we;
    end
  end

  assign cpu_rdata = r_rd_blt ? r_rdata : (r_rd_ram ? m_rdata : 8'h00);
  assign busy      = w_busy;
  assign irq       = r_done & r_irq_en;

endmodule
`default_nettype wire

// File: tb/tb_vram_blitter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_vram_blitter : vectors, corner sequences and random transfers vs model   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_vram_blitter;
  import vram_pkg::*;

  localparam int AW    = 13;
  localparam int LW    = 13;
  localparam int MEMSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_sel_ram, cpu_sel_blt, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din, cpu_rdata;
  logic          m_sel, m_we;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_wdata, m_rdata;
  logic          busy, irq;

  vram_blitter #(.AW(AW), .LW(LW)) dut (
    .clk(clk), .reset(reset),
    .cpu_sel_ram(cpu_sel_ram), .cpu_sel_blt(cpu_sel_blt), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_rdata(cpu_rdata),
    .m_sel(m_sel), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  // Video RAM stand-in: synchronous write, read data one cycle after the request.
  logic [7:0] mem     [MEMSZ];
  logic [7:0] ref_mem [MEMSZ];
  logic       ram_init;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < MEMSZ; i++) mem[i] <= ref_mem[i];
    end else if (m_sel && m_we) begin
      mem[m_addr] <= m_wdata;
    end
    if (m_sel && !m_we) m_rdata <= mem[m_addr];
  end

  int            busy_cnt;
  logic [AW-1:0] log_addr [$];
  logic [7:0]    log_data [$];
  always @(negedge clk) begin
    if (busy) busy_cnt <= busy_cnt + 1;
    if (m_sel && m_we && !cpu_sel_ram) begin
      log_addr.push_back(m_addr);
      log_data.push_back(m_wdata);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
    cpu_sel_blt = 1'b1; cpu_we = 1'b1; cpu_addr = AW'(a); cpu_din = d;
    tick();
    cpu_sel_blt = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = 8'h00;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [7:0] d);
    cpu_sel_blt = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(a);
    tick();
    cpu_sel_blt = 1'b0; cpu_addr = '0;
    d = cpu_rdata;
  endtask

  task automatic cpu_ram_wr(input logic [AW-1:0] a, input logic [7:0] d);
    cpu_sel_ram = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
    tick();
    cpu_sel_ram = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = 8'h00;
    ref_mem[a] = d;
  endtask

  task automatic cpu_ram_rd(input logic [AW-1:0] a, output logic [7:0] d);
    cpu_sel_ram = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    tick();
    cpu_sel_ram = 1'b0; cpu_addr = '0;
    d = cpu_rdata;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic program_regs(input logic [AW-1:0] dst, input logic [AW-1:0] src,
                              input logic [LW-1:0] len, input logic [7:0] fill);
    wr_reg(c_reg_dst_l, dst[7:0]);
    wr_reg(c_reg_dst_h, 8'(dst[AW-1:8]));
    wr_reg(c_reg_src_l, src[7:0]);
    wr_reg(c_reg_src_h, 8'(src[AW-1:8]));
    wr_reg(c_reg_len_l, len[7:0]);
    wr_reg(c_reg_len_h, 8'(len[LW-1:8]));
    wr_reg(c_reg_fill, fill);
  endtask

  // Reference: byte i goes to (dst+i) mod 2^AW, taken from the model memory as it stands.
  logic [AW-1:0] exp_a [$];
  logic [7:0]    exp_d [$];
  task automatic model_xfer(input bit mode, input logic [AW-1:0] dst, input logic [AW-1:0] src,
                            input int len, input logic [7:0] fill);
    int a, s;
    exp_a.delete();
    exp_d.delete();
    for (int i = 0; i < len; i++) begin
      a = (int'(dst) + i) % MEMSZ;
      s = (int'(src) + i) % MEMSZ;
      ref_mem[a] = mode ? ref_mem[s] : fill;
      exp_a.push_back(AW'(a));
      exp_d.push_back(ref_mem[a]);
    end
  endtask

  task automatic check_log(input string tag, input int l0);
    int bad = 0;
    check({tag, "_nwrites"}, log_addr.size() - l0, exp_a.size());
    for (int i = 0; i < exp_a.size(); i++) begin
      if (l0 + i >= log_addr.size()) bad++;
      else if (log_addr[l0+i] !== exp_a[i] || log_data[l0+i] !== exp_d[i]) bad++;
    end
    check({tag, "_write_seq_bad"}, bad, 0);
  endtask

  task automatic run_xfer(input string tag, input bit mode, input logic [AW-1:0] dst,
                          input logic [AW-1:0] src, input logic [LW-1:0] len,
                          input logic [7:0] fill, input int exp_busy);
    int b0, l0;
    logic [7:0] rd;
    program_regs(dst, src, len, fill);
    model_xfer(mode, dst, src, int'(len), fill);
    b0 = busy_cnt;
    l0 = log_addr.size();
    wr_reg(c_reg_ctrl, 8'h81 | {6'd0, mode, 1'b0});
    wait_idle(int'(len) * 3 + 20);
    check({tag, "_busy_cycles"}, busy_cnt - b0, exp_busy);
    check_log(tag, l0);
    rd_reg(c_reg_ctrl, rd);
    check({tag, "_ctrl"}, rd, 8'h80 | {6'd0, mode, 1'b0});
  endtask

  task automatic check_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < MEMSZ; i++) if (mem[i] !== ref_mem[i]) bad++;
    check(tag, bad, 0);
  endtask

  typedef struct {
    string         tag;
    bit            mode;
    logic [AW-1:0] dst;
    logic [AW-1:0] src;
    logic [LW-1:0] len;
    logic [7:0]    fill;
    int            exp_busy;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [7:0]    rd;
    int            b0, l0, len;
    bit            mode;
    logic [AW-1:0] dst, src;

    vecs[0] = '{"fill4",     1'b0, 13'h0100, 13'h0000, 13'd4, 8'h5A, 4};
    vecs[1] = '{"copy3",     1'b1, 13'h0300, 13'h0200, 13'd3, 8'h00, 9};
    vecs[2] = '{"fill_wrap", 1'b0, 13'h1FFE, 13'h0000, 13'd4, 8'hC3, 4};
    vecs[3] = '{"len0",      1'b0, 13'h0123, 13'h0000, 13'd0, 8'hEE, 0};
    vecs[4] = '{"copy_ovl",  1'b1, 13'h0402, 13'h0400, 13'd6, 8'h00, 18};
    vecs[5] = '{"copy_wrap", 1'b1, 13'h0010, 13'h1FFF, 13'd3, 8'h00, 9};

    reset = 1'b1; cpu_sel_ram = 1'b0; cpu_sel_blt = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_din = 8'h00; ram_init = 1'b1;
    for (int i = 0; i < MEMSZ; i++) ref_mem[i] = 8'($urandom);
    repeat (3) tick();
    ram_init = 1'b0;
    check("rst_m_sel", {31'd0, m_sel}, 0);
    check("rst_m_we", {31'd0, m_we}, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_wdata", m_wdata, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_irq", {31'd0, irq}, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    @(negedge clk) reset = 1'b0;
    tick();

    rd_reg(c_reg_ctrl, rd);   check("rst_ctrl", rd, 8'h00);
    rd_reg(c_reg_len_l, rd);  check("rst_len_l", rd, 8'h00);
    wr_reg(c_reg_dst_h, 8'hFF); rd_reg(c_reg_dst_h, rd); check("dst_h_mask", rd, 8'h1F);
    wr_reg(c_reg_len_h, 8'hFF); rd_reg(c_reg_len_h, rd); check("len_h_mask", rd, 8'h1F);
    wr_reg(c_reg_fill, 8'hA5);  rd_reg(c_reg_fill, rd);  check("fill_rb", rd, 8'hA5);

    cpu_ram_wr(13'h0200, 8'h11);
    cpu_ram_wr(13'h0201, 8'h22);
    cpu_ram_wr(13'h0202, 8'h33);

    for (int v = 0; v < 6; v++)
      run_xfer(vecs[v].tag, vecs[v].mode, vecs[v].dst, vecs[v].src,
               vecs[v].len, vecs[v].fill, vecs[v].exp_busy);

    cpu_ram_rd(13'h0300, rd); check("copy_byte0", rd, 8'h11);
    cpu_ram_rd(13'h0302, rd); check("copy_byte2", rd, 8'h33);
    cpu_ram_rd(13'h0000, rd); check("wrap_byte2", rd, 8'hC3);
    cpu_ram_rd(13'h1FFF, rd); check("wrap_byte1", rd, 8'hC3);

    // CPU steals the port for 3 cycles in the middle of a fill.
    program_regs(13'h0600, 13'h0000, 13'd8, 8'h3C);
    model_xfer(1'b0, 13'h0600, 13'h0000, 8, 8'h3C);
    b0 = busy_cnt; l0 = log_addr.size();
    wr_reg(c_reg_ctrl, 8'h81);
    tick();
    cpu_sel_ram = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0050; cpu_din = 8'hAA;
    repeat (3) tick();
    cpu_sel_ram = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = 8'h00;
    ref_mem[13'h0050] = 8'hAA;
    wait_idle(40);
    check("contend_busy_cycles", busy_cnt - b0, 11);
    check_log("contend", l0);
    cpu_ram_rd(13'h0050, rd); check("contend_cpu_write", rd, 8'hAA);

    // Abort after two bytes of a ten-byte fill.
    program_regs(13'h0700, 13'h0000, 13'd10, 8'h77);
    model_xfer(1'b0, 13'h0700, 13'h0000, 2, 8'h77);
    l0 = log_addr.size();
    wr_reg(c_reg_ctrl, 8'h81);
    tick();
    tick();
    wr_reg(c_reg_ctrl, 8'h08);
    check("abort_busy", {31'd0, busy}, 0);
    repeat (3) tick();
    check_log("abort", l0);
    rd_reg(c_reg_ctrl, rd); check("abort_ctrl", rd, 8'h00);

    // irq follows done while enabled; a done-clear drops it.
    program_regs(13'h0780, 13'h0000, 13'd2, 8'h99);
    model_xfer(1'b0, 13'h0780, 13'h0000, 2, 8'h99);
    wr_reg(c_reg_ctrl, 8'h85);
    check("irq_low_busy", {31'd0, irq}, 0);
    wait_idle(20);
    check("irq_rise", {31'd0, irq}, 1);
    tick();
    check("irq_hold", {31'd0, irq}, 1);
    wr_reg(c_reg_ctrl, 8'h84);
    check("irq_clear", {31'd0, irq}, 0);
    rd_reg(c_reg_ctrl, rd); check("irq_ctrl", rd, 8'h04);

    // Clear arriving in the DONE cycle loses to completion.
    program_regs(13'h07A0, 13'h0000, 13'd1, 8'h42);
    model_xfer(1'b0, 13'h07A0, 13'h0000, 1, 8'h42);
    wr_reg(c_reg_ctrl, 8'h81);
    wait_idle(10);
    wr_reg(c_reg_ctrl, 8'h80);
    rd_reg(c_reg_ctrl, rd); check("done_vs_clear", rd, 8'h80);

    for (int r = 0; r < 16; r++) begin
      mode = 1'($urandom_range(0, 1));
      dst  = AW'($urandom);
      src  = AW'($urandom);
      len  = int'($urandom_range(1, 24));
      run_xfer("rand", mode, dst, src, LW'(len), 8'($urandom), len * (mode ? 3 : 1));
    end
    check_mem("mem_after_random");

    // Asynchronous reset while a copy sits in WR: the pending write must not land.
    program_regs(13'h0A00, 13'h0900, 13'd6, 8'h00);
    l0 = log_addr.size();
    wr_reg(c_reg_ctrl, 8'h83);
    tick();
    tick();
    check("pre_reset_m_we", {31'd0, m_we}, 1);
    #2 reset = 1'b1;
    #1;
    check("areset_m_sel", {31'd0, m_sel}, 0);
    check("areset_m_we", {31'd0, m_we}, 0);
    check("areset_m_addr", m_addr, 0);
    check("areset_m_wdata", m_wdata, 0);
    check("areset_busy", {31'd0, busy}, 0);
    check("areset_irq", {31'd0, irq}, 0);
    check("areset_cpu_rdata", cpu_rdata, 0);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    tick();
    check("areset_nwrites", log_addr.size() - l0, 0);
    rd_reg(c_reg_src_h, rd); check("areset_src_h", rd, 8'h00);
    rd_reg(c_reg_ctrl, rd);  check("areset_ctrl", rd, 8'h00);
    run_xfer("post_reset_fill", 1'b0, 13'h0B00, 13'h0000, 13'd5, 8'hE1, 5);
    run_xfer("post_reset_copy", 1'b1, 13'h0C00, 13'h0B00, 13'd5, 8'h00, 15);
    check_mem("mem_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
